fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Sequencing controller for the resource-shared FIR filter: one signed multiplier and one accumulator are time-multiplexed across all taps, one tap per clock. Owns the sample delay line and coefficient file, arbitrates between the sample stream and coefficient writes, and presents each filtered result on a valid/ready output. Sits between the sample source and the downstream consumer, replacing the free-running filter core.

## Interface
- TAPS, 10, number of filter taps (2..16)
- DATA_W, 8, signed sample width
- COEF_W, 8, signed coefficient width
- OUT_W, 25, signed output width; must be ≥ DATA_W+COEF_W+clog2(TAPS)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- InputData  in  DATA_W  signed sample
- InValid  in  1  sample offered
- InReady  out  1  sample accepted on edge where InValid && InReady
- CoefficientIndex  in  4  tap to write
- NewCoefficientValue  in  COEF_W  signed coefficient
- CoefficientWriteEnable  in  1  write request, held until acknowledged
- CoefficientWriteReady  out  1  write performed on edge where enable && ready
- FilteredOutput  out  OUT_W  signed result, stable while OutValid
- OutValid  out  1  result available
- OutReady  in  1  consumer accepts result
- Busy  out  1  high in MAC or DONE

## Operation
- States: IDLE, MAC, DONE.
- IDLE: CoefficientWriteReady=1; InReady = !CoefficientWriteEnable (coefficient write has priority).
- Write edge: coef[CoefficientIndex] <= NewCoefficientValue; index ≥ TAPS acknowledged, no change. Stay IDLE.
- Accept edge: delay line shifts (d[0] <= InputData, d[k] <= d[k-1]), acc <= 0, tap idx <= 0, → MAC.
- MAC: each edge acc += sign-extended d[idx]*coef[idx] (full DATA_W+COEF_W product, signed); idx++. On edge with idx==TAPS-1, FilteredOutput <= acc + product, OutValid <= 1, → DONE.
- DONE: holds FilteredOutput/OutValid; on edge with OutReady → IDLE, OutValid <= 0.
- InReady and CoefficientWriteReady are 0 in MAC and DONE; requests are held off, never dropped.
- Reset (any time, including mid-MAC): state IDLE, delay line, coefficients, acc, idx, FilteredOutput all 0, OutValid 0; in-flight sample discarded.
- Reset output values: InReady 1 (if no write pending), CoefficientWriteReady 1, OutValid 0, FilteredOutput 0, Busy 0.

## Timing
- Accept edge E → OutValid high after edge E+TAPS (TAPS cycles latency).
- With OutReady held high: DONE lasts 1 cycle, max throughput one sample per TAPS+2 cycles.
- Coefficient write takes effect on the next accepted sample; one write per cycle in IDLE.
- Simultaneous InValid and CoefficientWriteEnable in IDLE: write first, sample accepted earliest next cycle.
- All outputs registered except InReady and CoefficientWriteReady (state-decoded, InReady also from CoefficientWriteEnable).

## Configuration
- FIR_SCHED_PERF_CNT_EN defined: extra output SampleCount (16 bits), increments on each result handshake (OutValid && OutReady), wraps 0xFFFF→0, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package fir_sched_pkg: state enum (IDLE, MAC, DONE), default TAPS/DATA_W/COEF_W/OUT_W constants, tap-index width.
- One sub-module: fir_mac_unit (signed multiply, accumulator with clear and enable, OUT_W wide); scheduler FSM, delay line and coefficient file in the top.

## Test plan
- Write coef[i]=i+1 for i=0..9, feed 1 then nine 0s, OutReady=1 → results 1,2,…,10; following 0 → 0.
- All coefficients -128, ten samples -128 → tenth result 163840, no overflow at OUT_W=25.
- Hold InValid and CoefficientWriteEnable together in IDLE → write acknowledged first, InReady 0 that cycle, sample accepted next cycle using new coefficient.
- OutReady low 5 cycles after OutValid → FilteredOutput stable, InReady 0, next sample accepted only after handshake; write to index 12 → acknowledged, coefficients unchanged.
- Assert Reset at MAC cycle 4 → OutValid stays 0, all outputs reset values, next impulse with no writes → result 0.
- With FIR_SCHED_PERF_CNT_EN: 3 result handshakes → SampleCount 3; reset → 0.

Source files
------------

// File: rtl/fir_mac_scheduler_pkg.sv
// rtl/fir_mac_scheduler_pkg.sv - shared types and default sizes for the shared-MAC FIR scheduler
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  localparam int TAPS_DEF   = 10;
  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int OUT_W_DEF  = 25;

  // Wide enough for TAPS up to 16 and matches the coefficient index port
  localparam int IDX_W = 4;

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// rtl/fir_mac_scheduler_if.sv - sample, coefficient-write and result handshake bundle
interface fir_mac_scheduler_if
  import fir_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);
  logic signed [DATA_W-1:0] InputData;
  logic                     InValid;
  logic                     InReady;
  logic        [IDX_W-1:0]  CoefficientIndex;
  logic signed [COEF_W-1:0] NewCoefficientValue;
  logic                     CoefficientWriteEnable;
  logic                     CoefficientWriteReady;
  logic signed [OUT_W-1:0]  FilteredOutput;
  logic                     OutValid;
  logic                     OutReady;
  logic                     Busy;

  // Source/consumer side
  modport master (
    output InputData, InValid, CoefficientIndex, NewCoefficientValue,
           CoefficientWriteEnable, OutReady,
    input  InReady, CoefficientWriteReady, FilteredOutput, OutValid, Busy
  );

  // Scheduler side
  modport slave (
    input  InputData, InValid, CoefficientIndex, NewCoefficientValue,
           CoefficientWriteEnable, OutReady,
    output InReady, CoefficientWriteReady, FilteredOutput, OutValid, Busy
  );

endinterface

// File: rtl/fir_mac_scheduler_mac_unit.sv
// rtl/fir_mac_scheduler_mac_unit.sv - signed multiplier feeding a clearable accumulator
module fir_mac_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [OUT_W-1:0]  sum_o
);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  prod_ext;
  logic signed [OUT_W-1:0]  acc_q;

  assign prod     = a_i * b_i;
  assign prod_ext = {{(OUT_W - PROD_W){prod[PROD_W-1]}}, prod};
  // sum_o is also the final result on the last tap, so it is exported unregistered
  assign sum_o    = acc_q + prod_ext;

  // Accumulator: clear wins over accumulate so a new sample always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - one-tap-per-clock FIR sequencer; optional SampleCount via FIR_SCHED_PERF_CNT_EN
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic Clk,
  input  logic Reset,
  fir_mac_scheduler_if.slave bus
`ifdef FIR_SCHED_PERF_CNT_EN
  ,
  output logic [15:0] SampleCount
`endif
);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);
  localparam logic [IDX_W:0]   TAPS_LIM = (IDX_W + 1)'(TAPS);

  fir_state_e               state_q;
  logic        [IDX_W-1:0]  idx_q;
  logic        [IDX_W-1:0]  idx_d;
  logic signed [DATA_W-1:0] dly_q  [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [OUT_W-1:0]  result_q;
  logic signed [OUT_W-1:0]  mac_sum;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     idle;
  logic                     wr_fire;
  logic                     accept;

  // Coefficient writes take priority over samples while idle
  assign idle    = (state_q == IDLE);
  assign wr_fire = idle && bus.CoefficientWriteEnable;
  assign accept  = idle && bus.InValid && !bus.CoefficientWriteEnable;
  assign idx_d   = idx_q + IDX_W'(1);

  assign bus.InReady               = idle && !bus.CoefficientWriteEnable;
  assign bus.CoefficientWriteReady = idle;
  assign bus.FilteredOutput        = result_q;
  assign bus.OutValid              = out_valid_q;
  assign bus.Busy                  = busy_q;

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk   (Clk),
    .rst   (Reset),
    .clr_i (accept),
    .en_i  (state_q == MAC),
    .a_i   (dly_q[idx_q]),
    .b_i   (coef_q[idx_q]),
    .sum_o (mac_sum)
  );

  // Delay line shifts only on an accepted sample; out-of-range writes are acknowledged but dropped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < TAPS; k++) begin
        dly_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        dly_q[0] <= bus.InputData;
        for (int k = 1; k < TAPS; k++) dly_q[k] <= dly_q[k-1];
      end
      if (wr_fire && ({1'b0, bus.CoefficientIndex} < TAPS_LIM)) begin
        coef_q[bus.CoefficientIndex] <= bus.NewCoefficientValue;
      end
    end
  end

  // Scheduler FSM: IDLE accepts, MAC walks taps, DONE holds the result until taken
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (idx_q == LAST_TAP) begin
            result_q    <= mac_sum;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          if (bus.OutReady) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIR_SCHED_PERF_CNT_EN
  logic [15:0] sample_cnt_q;
  assign SampleCount = sample_cnt_q;

  // Counts result handshakes, wrapping naturally at 16 bits
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sample_cnt_q <= '0;
    end else if (out_valid_q && bus.OutReady) begin
      sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - directed self-checking bench for fir_mac_scheduler
module tb_fir_mac_scheduler;
  import fir_sched_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fir_mac_scheduler_if bus ();
`ifdef FIR_SCHED_PERF_CNT_EN
  logic [15:0] SampleCount;
`endif

  fir_mac_scheduler dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef FIR_SCHED_PERF_CNT_EN
    ,
    .SampleCount (SampleCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic idle_inputs();
    bus.InputData              = '0;
    bus.InValid                = 1'b0;
    bus.CoefficientIndex       = '0;
    bus.NewCoefficientValue    = '0;
    bus.CoefficientWriteEnable = 1'b0;
    bus.OutReady               = 1'b1;
  endtask

  task automatic write_coef(input logic [3:0] i, input logic signed [7:0] v);
    bus.CoefficientIndex       = i;
    bus.NewCoefficientValue    = v;
    bus.CoefficientWriteEnable = 1'b1;
    @(posedge Clk); #1;
    bus.CoefficientWriteEnable = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    while (!bus.OutValid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    to = !bus.OutValid;
  endtask

  // Offers x in IDLE, waits for the result, then lets the OutReady handshake complete
  task automatic run_sample(input logic signed [7:0] x, output logic signed [24:0] y,
                            output int lat, output bit to);
    bus.InputData = x;
    bus.InValid   = 1'b1;
    @(posedge Clk); #1;
    bus.InValid   = 1'b0;
    wait_valid(lat, to);
    y = bus.FilteredOutput;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #12;
    checks++; if (bus.InReady !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.InReady); end
    checks++; if (bus.CoefficientWriteReady !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", bus.CoefficientWriteReady); end
    checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.OutValid); end
    checks++; if (bus.FilteredOutput !== 25'sd0) begin errors++; $display("FAIL reset_output: got %0d want 0", bus.FilteredOutput); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
`ifdef FIR_SCHED_PERF_CNT_EN
    checks++; if (SampleCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", SampleCount); end
`endif
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_impulse();
    logic signed [24:0] y;
    logic signed [24:0] exp_y;
    int lat;
    bit to;
    for (int i = 0; i < 10; i++) write_coef(4'(i), 8'(i + 1));
    for (int n = 0; n < 11; n++) begin
      run_sample((n == 0) ? 8'sd1 : 8'sd0, y, lat, to);
      exp_y = (n < 10) ? 25'(n + 1) : 25'sd0;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL impulse_timeout[%0d]: got %b want 0", n, to); end
      checks++; if (y !== exp_y) begin errors++; $display("FAIL impulse_result[%0d]: got %0d want %0d", n, y, exp_y); end
      if (n == 0) begin
        checks++; if (lat !== 10) begin errors++; $display("FAIL impulse_latency: got %0d want 10", lat); end
      end
    end
  endtask

  task automatic test_full_scale();
    logic signed [24:0] y;
    logic signed [24:0] exp_y;
    int lat;
    bit to;
    for (int i = 0; i < 10; i++) write_coef(4'(i), -8'sd128);
    for (int n = 1; n <= 10; n++) begin
      run_sample(-8'sd128, y, lat, to);
      exp_y = 25'(n * 16384);
      checks++; if (y !== exp_y || to) begin errors++; $display("FAIL full_scale[%0d]: got %0d want %0d", n, y, exp_y); end
    end
  endtask

  task automatic test_priority();
    int lat;
    bit to;
    bus.CoefficientIndex       = 4'd0;
    bus.NewCoefficientValue    = 8'sd5;
    bus.CoefficientWriteEnable = 1'b1;
    bus.InputData              = 8'sd3;
    bus.InValid                = 1'b1;
    #1;
    checks++; if (bus.InReady !== 1'b0) begin errors++; $display("FAIL prio_in_ready_held: got %b want 0", bus.InReady); end
    checks++; if (bus.CoefficientWriteReady !== 1'b1) begin errors++; $display("FAIL prio_wr_ready: got %b want 1", bus.CoefficientWriteReady); end
    @(posedge Clk); #1;
    bus.CoefficientWriteEnable = 1'b0;
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL prio_not_started: got %b want 0", bus.Busy); end
    checks++; if (bus.InReady !== 1'b1) begin errors++; $display("FAIL prio_in_ready_next: got %b want 1", bus.InReady); end
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    wait_valid(lat, to);
    checks++; if (bus.FilteredOutput !== 25'sd147471 || to) begin errors++; $display("FAIL prio_result: got %0d want 147471", bus.FilteredOutput); end
    @(posedge Clk); #1;
  endtask

  task automatic test_backpressure();
    logic signed [24:0] y;
    int lat;
    bit to;
    bus.OutReady  = 1'b0;
    bus.InputData = 8'sd0;
    bus.InValid   = 1'b1;
    @(posedge Clk); #1;
    bus.InputData = 8'sd7;
    wait_valid(lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", to); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.FilteredOutput !== 25'sd130688 || bus.OutValid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %0d/%b want 130688/1", c, bus.FilteredOutput, bus.OutValid); end
      checks++; if (bus.InReady !== 1'b0 || bus.CoefficientWriteReady !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b%b want 00", c, bus.InReady, bus.CoefficientWriteReady); end
      @(posedge Clk); #1;
    end
    bus.OutReady = 1'b1;
    @(posedge Clk); #1;
    checks++; if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b ready %b want 0 1", bus.OutValid, bus.InReady); end
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL bp_held_sample_accepted: got %b want 1", bus.Busy); end
    wait_valid(lat, to);
    checks++; if (bus.FilteredOutput !== 25'sd114339 || to) begin errors++; $display("FAIL bp_held_result: got %0d want 114339", bus.FilteredOutput); end
    @(posedge Clk); #1;
    bus.CoefficientIndex       = 4'd12;
    bus.NewCoefficientValue    = 8'sd99;
    bus.CoefficientWriteEnable = 1'b1;
    #1;
    checks++; if (bus.CoefficientWriteReady !== 1'b1) begin errors++; $display("FAIL bad_index_ack: got %b want 1", bus.CoefficientWriteReady); end
    @(posedge Clk); #1;
    bus.CoefficientWriteEnable = 1'b0;
    run_sample(8'sd0, y, lat, to);
    checks++; if (y !== 25'sd97024 || to) begin errors++; $display("FAIL bad_index_no_change: got %0d want 97024", y); end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [24:0] y;
    int lat;
    bit to;
    bit seen;
    bus.InputData = 8'sd5;
    bus.InValid   = 1'b1;
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    checks++; if (bus.InReady !== 1'b1 || bus.CoefficientWriteReady !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b%b want 11", bus.InReady, bus.CoefficientWriteReady); end
    checks++; if (bus.OutValid !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL mid_reset_valid_busy: got %b%b want 00", bus.OutValid, bus.Busy); end
    checks++; if (bus.FilteredOutput !== 25'sd0) begin errors++; $display("FAIL mid_reset_output: got %0d want 0", bus.FilteredOutput); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (bus.OutValid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_result: got %b want 0", seen); end
    run_sample(8'sd1, y, lat, to);
    checks++; if (y !== 25'sd0 || to) begin errors++; $display("FAIL post_reset_impulse: got %0d want 0", y); end
  endtask

`ifdef FIR_SCHED_PERF_CNT_EN
  task automatic test_perf_count();
    logic signed [24:0] y;
    int lat;
    bit to;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++; if (SampleCount !== 16'd0) begin errors++; $display("FAIL perf_start: got %0d want 0", SampleCount); end
    repeat (3) run_sample(8'sd2, y, lat, to);
    checks++; if (SampleCount !== 16'd3) begin errors++; $display("FAIL perf_three: got %0d want 3", SampleCount); end
    Reset = 1'b1;
    #1;
    checks++; if (SampleCount !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d want 0", SampleCount); end
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_impulse();
    test_full_scale();
    test_priority();
    test_backpressure();
    test_reset_mid_mac();
`ifdef FIR_SCHED_PERF_CNT_EN
    test_perf_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
